down_counter_loadable: RTL

// - Synchronous loadable down-counter/timer: the count-down counterpart to the team's ripple up-counter.
// - Parallel-loads a start value, decrements on enable, flags terminal count with a one-cycle done pulse.
// - Used as the programmable timeout/interval source next to the up-counter in the counter datapath.

---
 rtl/down_counter_loadable.sv | 94 +++++++++
 1 files changed

// File: rtl/down_counter_loadable.sv
// Loadable down-counter/timer with one-cycle done pulse at terminal count.
// Define DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload from the last loaded value.
module down_counter_loadable #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             wr,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] EXPIRE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] q_nxt;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload <= '0;
    end else if (wr) begin
      reload <= d;
    end
  end
`endif

  // A load overrides every state transition, including the EXPIRE exit.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    if (wr) begin
      q_nxt     = d;
      state_nxt = (d != '0) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
        end
        RUN: begin
          if (en) begin
            if (q == ONE) begin
              q_nxt     = '0;
              state_nxt = EXPIRE;
            end else begin
              q_nxt = q - ONE;
            end
          end
        end
        EXPIRE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload != '0) begin
            q_nxt     = reload;
            state_nxt = RUN;
          end else begin
            q_nxt     = '0;
            state_nxt = IDLE;
          end
`else
          q_nxt     = '0;
          state_nxt = IDLE;
`endif
        end
        default: begin
          q_nxt     = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      state <= IDLE;
    end else begin
      q     <= q_nxt;
      state <= state_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == EXPIRE);

endmodule
